// File: rtl/qm_decode_if.sv
// qm_decode_if: signal bundle around the decode stage.
//   fetch side : if_valid, if_instr, if_pc in; if_stall out
//   EX control : ex_stall, ex_flush in
//   reg file   : rf_ra1/rf_ra2 out, rf_rd1/rf_rd2 in
//   writeback  : wb_we, wb_wa, wb_wd in (bypass source)
//   ID/EX reg  : id_* out
// master = the decode stage, slave = the surrounding pipeline.
interface qm_decode_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_stall;
  logic        ex_stall;
  logic        ex_flush;
  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic [31:0] id_imm;
  logic [4:0]  id_dest;
  logic [3:0]  id_alu_op;
  logic        id_alu_imm;
  logic        id_reg_we;
  logic        id_mem_rd;
  logic        id_mem_wr;
  logic        id_br_eq;
  logic        id_br_ne;
  logic        id_illegal;

  modport master (
    input  if_valid, if_instr, if_pc, ex_stall, ex_flush,
           rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd,
    output if_stall, rf_ra1, rf_ra2,
           id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_dest,
           id_alu_op, id_alu_imm, id_reg_we, id_mem_rd, id_mem_wr,
           id_br_eq, id_br_ne, id_illegal
  );

  modport slave (
    output if_valid, if_instr, if_pc, ex_stall, ex_flush,
           rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd,
    input  if_stall, rf_ra1, rf_ra2,
           id_valid, id_pc, id_rs_val, id_rt_val, id_imm, id_dest,
           id_alu_op, id_alu_imm, id_reg_we, id_mem_rd, id_mem_wr,
           id_br_eq, id_br_ne, id_illegal
  );
endinterface

// File: rtl/qm_decode.sv
// qm_decode: instruction decode stage of the q3kmips pipeline.
// Decodes the fetched word, reads the register file, bypasses the
// same-cycle writeback, inserts a bubble on load-use hazards and
// registers the result into the ID/EX pipeline register.
// Ports: clk, reset_n (async active-low), bus (qm_decode_if.master).
module qm_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic        clk,
  input logic        reset_n,
  qm_decode_if.master bus
);

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2,
                         ALU_OR  = 4'd3, ALU_XOR = 4'd4, ALU_SLT = 4'd5,
                         ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_PASSB = 4'd8;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] sext, zext;

  assign op    = bus.if_instr[31:26];
  assign rs    = bus.if_instr[25:21];
  assign rt    = bus.if_instr[20:16];
  assign rd    = bus.if_instr[15:11];
  assign shamt = bus.if_instr[10:6];
  assign funct = bus.if_instr[5:0];
  assign imm16 = bus.if_instr[15:0];
  assign sext  = {{16{imm16[15]}}, imm16};
  assign zext  = {16'h0000, imm16};

  assign bus.rf_ra1 = rs;
  assign bus.rf_ra2 = rt;

  logic [3:0]  d_alu_op;
  logic [31:0] d_imm;
  logic [4:0]  d_dest;
  logic        d_alu_imm, d_we, d_rd, d_wr, d_beq, d_bne, d_ill;
  logic        reads_rs, reads_rt;

  always_comb begin
    d_alu_op  = ALU_ADD;
    d_imm     = '0;
    d_dest    = '0;
    d_alu_imm = 1'b0;
    d_we      = 1'b0;
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    d_beq     = 1'b0;
    d_bne     = 1'b0;
    d_ill     = 1'b0;
    reads_rs  = 1'b1;
    reads_rt  = 1'b0;
    case (op)
      6'h00: begin
        reads_rt = 1'b1;
        d_dest   = rd;
        d_we     = 1'b1;
        case (funct)
          6'h21: d_alu_op = ALU_ADD;
          6'h23: d_alu_op = ALU_SUB;
          6'h24: d_alu_op = ALU_AND;
          6'h25: d_alu_op = ALU_OR;
          6'h26: d_alu_op = ALU_XOR;
          6'h2A: d_alu_op = ALU_SLT;
          6'h00, 6'h02: begin
            // shifts take the amount from the word, only rt is a source
            d_alu_op  = (funct == 6'h00) ? ALU_SLL : ALU_SRL;
            d_imm     = {27'd0, shamt};
            d_alu_imm = 1'b1;
            reads_rs  = 1'b0;
          end
          default: d_ill = 1'b1;
        endcase
      end
      6'h09: begin d_alu_op = ALU_ADD; d_imm = sext; d_alu_imm = 1'b1; d_dest = rt; d_we = 1'b1; end
      6'h0A: begin d_alu_op = ALU_SLT; d_imm = sext; d_alu_imm = 1'b1; d_dest = rt; d_we = 1'b1; end
      6'h0C: begin d_alu_op = ALU_AND; d_imm = zext; d_alu_imm = 1'b1; d_dest = rt; d_we = 1'b1; end
      6'h0D: begin d_alu_op = ALU_OR;  d_imm = zext; d_alu_imm = 1'b1; d_dest = rt; d_we = 1'b1; end
      6'h0F: begin
        d_alu_op  = ALU_PASSB;
        d_imm     = {imm16, 16'h0000};
        d_alu_imm = 1'b1;
        d_dest    = rt;
        d_we      = 1'b1;
        reads_rs  = 1'b0;
      end
      6'h23: begin d_alu_op = ALU_ADD; d_imm = sext; d_alu_imm = 1'b1; d_dest = rt; d_we = 1'b1; d_rd = 1'b1; end
      6'h2B: begin d_alu_op = ALU_ADD; d_imm = sext; d_alu_imm = 1'b1; d_wr = 1'b1; reads_rt = 1'b1; end
      6'h04, 6'h05: begin
        d_alu_op = ALU_SUB;
        d_imm    = {sext[29:0], 2'b00};
        d_beq    = (op == 6'h04);
        d_bne    = (op == 6'h05);
        reads_rt = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_we     = 1'b0;
      d_rd     = 1'b0;
      d_wr     = 1'b0;
      d_beq    = 1'b0;
      d_bne    = 1'b0;
      d_dest   = '0;
      reads_rs = 1'b0;
      reads_rt = 1'b0;
    end
    if (d_dest == 5'd0) d_we = 1'b0;
  end

  // writeback lands in the file on this same edge, so forward it here
  logic [31:0] rs_val, rt_val;
  assign rs_val = (bus.wb_we && bus.wb_wa != 5'd0 && bus.wb_wa == rs) ? bus.wb_wd : bus.rf_rd1;
  assign rt_val = (bus.wb_we && bus.wb_wa != 5'd0 && bus.wb_wa == rt) ? bus.wb_wd : bus.rf_rd2;

  logic hz;
  assign hz = bus.id_valid && bus.id_mem_rd && bus.if_valid &&
              ((reads_rs && bus.id_dest == rs) || (reads_rt && bus.id_dest == rt));

  // a flush redirects fetch, so a pending hazard must not hold it
  assign bus.if_stall = bus.ex_stall | (hz & ~bus.ex_flush);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.id_valid   <= 1'b0;
      bus.id_pc      <= RESET_PC;
      bus.id_rs_val  <= '0;
      bus.id_rt_val  <= '0;
      bus.id_imm     <= '0;
      bus.id_dest    <= '0;
      bus.id_alu_op  <= '0;
      bus.id_alu_imm <= 1'b0;
      bus.id_reg_we  <= 1'b0;
      bus.id_mem_rd  <= 1'b0;
      bus.id_mem_wr  <= 1'b0;
      bus.id_br_eq   <= 1'b0;
      bus.id_br_ne   <= 1'b0;
      bus.id_illegal <= 1'b0;
    end else if (bus.ex_stall) begin
      // hold everything; a concurrent flush is re-presented after the stall
    end else if (bus.ex_flush || hz || !bus.if_valid) begin
      bus.id_valid <= 1'b0;
    end else begin
      bus.id_valid   <= 1'b1;
      bus.id_pc      <= bus.if_pc;
      bus.id_rs_val  <= rs_val;
      bus.id_rt_val  <= rt_val;
      bus.id_imm     <= d_imm;
      bus.id_dest    <= d_dest;
      bus.id_alu_op  <= d_alu_op;
      bus.id_alu_imm <= d_alu_imm;
      bus.id_reg_we  <= d_we;
      bus.id_mem_rd  <= d_rd;
      bus.id_mem_wr  <= d_wr;
      bus.id_br_eq   <= d_beq;
      bus.id_br_ne   <= d_bne;
      bus.id_illegal <= d_ill;
    end
  end

endmodule

// File: tb/tb_qm_decode.sv
// tb_qm_decode: scoreboard bench for the qm_decode stage.
module tb_qm_decode;
  localparam logic [31:0] RP = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [3:0]  alu_op;
    logic        alu_imm;
    logic        reg_we;
    logic        mem_rd;
    logic        mem_wr;
    logic        br_eq;
    logic        br_ne;
    logic        illegal;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  qm_decode_if bus();
  qm_decode #(.RESET_PC(RP)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  ent_t sb[$];

  // register file model: distinct value per register, r0 reads zero
  function automatic logic [31:0] rfv(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : {3'b000, a, 8'hA5, 3'b000, a, 8'h5A};
  endfunction
  assign bus.rf_rd1 = rfv(bus.rf_ra1);
  assign bus.rf_rd2 = rfv(bus.rf_ra2);

  function automatic ent_t mk(input logic [31:0] pc, rsv, rtv, imm, input logic [4:0] dest,
                              input logic [3:0] aop, input logic ai, we, mr, mw, beq, bne, ill);
    ent_t e;
    e = '{pc, rsv, rtv, imm, dest, aop, ai, we, mr, mw, beq, bne, ill};
    return e;
  endfunction

  function automatic ent_t obs();
    return '{bus.id_pc, bus.id_rs_val, bus.id_rt_val, bus.id_imm, bus.id_dest, bus.id_alu_op,
             bus.id_alu_imm, bus.id_reg_we, bus.id_mem_rd, bus.id_mem_wr, bus.id_br_eq,
             bus.id_br_ne, bus.id_illegal};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc    = pc;
  endtask

  task automatic test_reset();
    ent_t e;
    reset_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.ex_stall = 1'b0;
    bus.ex_flush = 1'b0;
    bus.wb_we = 1'b0;
    bus.wb_wa = 5'd0;
    bus.wb_wd = 32'h0;
    #3;
    step();
    step();
    e = mk(RP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.id_valid); end
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL reset_fields: got %h expected %h", obs(), e); end
    checks++;
    if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL reset_if_stall: got %b expected 0", bus.if_stall); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    logic [31:0] ins [9];
    ent_t ex [9];
    ent_t e;
    logic [31:0] pc;
    ins[0] = 32'h24020005; // ADDIU r2,r0,5
    ins[1] = 32'h2402FFFF; // ADDIU r2,r0,-1
    ins[2] = 32'h3C031234; // LUI r3,0x1234
    ins[3] = 32'h000321C0; // SLL r4,r3,7
    ins[4] = 32'h1022FFFF; // BEQ r1,r2,-1
    ins[5] = 32'h3420FFFF; // ORI r0,r1,0xFFFF
    ins[6] = 32'hAC450008; // SW r5,8(r2)
    ins[7] = 32'h0043202A; // SLT r4,r2,r3
    ins[8] = 32'h28A7FFFE; // SLTI r7,r5,-2
    for (int i = 0; i < 9; i++) begin
      pc = 32'h400 + 32'(i * 4);
      case (i)
        0: ex[i] = mk(pc, 0, rfv(2), 32'h5, 2, 0, 1, 1, 0, 0, 0, 0, 0);
        1: ex[i] = mk(pc, 0, rfv(2), 32'hFFFFFFFF, 2, 0, 1, 1, 0, 0, 0, 0, 0);
        2: ex[i] = mk(pc, 0, rfv(3), 32'h12340000, 3, 8, 1, 1, 0, 0, 0, 0, 0);
        3: ex[i] = mk(pc, 0, rfv(3), 32'h7, 4, 6, 1, 1, 0, 0, 0, 0, 0);
        4: ex[i] = mk(pc, rfv(1), rfv(2), 32'hFFFFFFFC, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        5: ex[i] = mk(pc, rfv(1), 0, 32'h0000FFFF, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        6: ex[i] = mk(pc, rfv(2), rfv(5), 32'h8, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        7: ex[i] = mk(pc, rfv(2), rfv(3), 32'h0, 4, 5, 0, 1, 0, 0, 0, 0, 0);
        default: ex[i] = mk(pc, rfv(5), rfv(7), 32'hFFFFFFFE, 7, 5, 1, 1, 0, 0, 0, 0, 0);
      endcase
      drive(1'b1, ins[i], pc);
      sb.push_back(ex[i]);
      step();
      checks++;
      if (bus.id_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL decode_%0d_valid: got %b expected 1", i, bus.id_valid);
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (obs() !== e) begin errors++; $display("FAIL decode_%0d: got %h expected %h", i, obs(), e); end
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    ins[0] = 32'hFC000000;
    ins[1] = 32'h0000003F;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ins[i], 32'h480 + 32'(i * 4));
      step();
      checks++;
      if ({bus.id_valid, bus.id_illegal, bus.id_reg_we, bus.id_mem_rd, bus.id_mem_wr,
           bus.id_br_eq, bus.id_br_ne} !== 7'b1100000) begin
        errors++;
        $display("FAIL illegal_%0d: got v/ill/we/rd/wr/beq/bne=%b expected 1100000", i,
                 {bus.id_valid, bus.id_illegal, bus.id_reg_we, bus.id_mem_rd, bus.id_mem_wr,
                  bus.id_br_eq, bus.id_br_ne});
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_bypass();
    logic [31:0] ins [4];
    logic [4:0]  wa [4];
    logic        we [4];
    ent_t ex [4];
    ent_t e;
    ins[0] = 32'h00602021; wa[0] = 5'd3; we[0] = 1'b1; // ADDU r4,r3,r0
    ins[1] = 32'h00602021; wa[1] = 5'd0; we[1] = 1'b1;
    ins[2] = 32'h00032021; wa[2] = 5'd3; we[2] = 1'b1; // ADDU r4,r0,r3
    ins[3] = 32'h00602021; wa[3] = 5'd3; we[3] = 1'b0;
    ex[0] = mk(32'h500, 32'hDEADBEEF, 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0);
    ex[1] = mk(32'h504, rfv(3), 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0);
    ex[2] = mk(32'h508, 0, 32'hDEADBEEF, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0);
    ex[3] = mk(32'h50C, rfv(3), 0, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0);
    bus.wb_wd = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      bus.wb_we = we[i];
      bus.wb_wa = wa[i];
      drive(1'b1, ins[i], 32'h500 + 32'(i * 4));
      sb.push_back(ex[i]);
      step();
      checks++;
      if (bus.id_valid !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL bypass_%0d_valid: got %b expected 1", i, bus.id_valid);
        sb.delete();
      end else begin
        e = sb.pop_front();
        if (obs() !== e) begin errors++; $display("FAIL bypass_%0d: got %h expected %h", i, obs(), e); end
      end
    end
    bus.wb_we = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_load_use();
    ent_t e;
    // LW r5,0(r1)
    drive(1'b1, 32'h8C250000, 32'h600);
    sb.push_back(mk(32'h600, rfv(1), rfv(5), 0, 5, 0, 1, 1, 1, 0, 0, 0, 0));
    step();
    e = sb.pop_front();
    checks++;
    if (bus.id_valid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL lw_capture: got %b/%h expected 1/%h", bus.id_valid, obs(), e); end
    // ADDU r6,r5,r0 uses the load result
    drive(1'b1, 32'h00A03021, 32'h604);
    #1;
    checks++;
    if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL hz_rs_stall: got %b expected 1", bus.if_stall); end
    step();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL hz_bubble: got %b expected 0", bus.id_valid); end
    checks++;
    if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL hz_release: got %b expected 0", bus.if_stall); end
    // the load writes back while the follower is re-decoded
    bus.wb_we = 1'b1;
    bus.wb_wa = 5'd5;
    bus.wb_wd = 32'h5555AAAA;
    sb.push_back(mk(32'h604, 32'h5555AAAA, 0, 0, 6, 0, 0, 1, 0, 0, 0, 0, 0));
    step();
    bus.wb_we = 1'b0;
    e = sb.pop_front();
    checks++;
    if (bus.id_valid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL hz_follower: got %b/%h expected 1/%h", bus.id_valid, obs(), e); end
    // independent follower: no stall
    drive(1'b1, 32'h8C250000, 32'h608);
    step();
    drive(1'b1, 32'h24E60001, 32'h60C);
    #1;
    checks++;
    if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL nohz_stall: got %b expected 0", bus.if_stall); end
    sb.push_back(mk(32'h60C, rfv(7), rfv(6), 1, 6, 0, 1, 1, 0, 0, 0, 0, 0));
    step();
    e = sb.pop_front();
    checks++;
    if (bus.id_valid !== 1'b1 || obs() !== e) begin errors++; $display("FAIL nohz_capture: got %b/%h expected 1/%h", bus.id_valid, obs(), e); end
    // SW r5 after LW r5: hazard through rt, then a flush cancels it
    drive(1'b1, 32'h8C250000, 32'h610);
    step();
    drive(1'b1, 32'hAC450008, 32'h614);
    #1;
    checks++;
    if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL hz_rt_stall: got %b expected 1", bus.if_stall); end
    bus.ex_flush = 1'b1;
    #1;
    checks++;
    if (bus.if_stall !== 1'b0) begin errors++; $display("FAIL hz_flush_stall: got %b expected 0", bus.if_stall); end
    step();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL hz_flush_valid: got %b expected 0", bus.id_valid); end
    bus.ex_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_stall_flush();
    ent_t held;
    drive(1'b1, 32'h24020005, 32'h700);
    sb.push_back(mk(32'h700, 0, rfv(2), 5, 2, 0, 1, 1, 0, 0, 0, 0, 0));
    step();
    held = sb.pop_front();
    checks++;
    if (bus.id_valid !== 1'b1 || obs() !== held) begin errors++; $display("FAIL stall_setup: got %b/%h expected 1/%h", bus.id_valid, obs(), held); end
    drive(1'b1, 32'h3420FFFF, 32'h704);
    bus.ex_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.ex_flush = 1'b1; // stall wins over a concurrent flush
      #1;
      checks++;
      if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL stall_%0d_if_stall: got %b expected 1", i, bus.if_stall); end
      step();
      checks++;
      if (bus.id_valid !== 1'b1 || obs() !== held) begin errors++; $display("FAIL stall_%0d_hold: got %b/%h expected 1/%h", i, bus.id_valid, obs(), held); end
    end
    bus.ex_stall = 1'b0;
    step();
    checks++;
    if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.id_valid); end
    bus.ex_flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_async_reset();
    ent_t e;
    drive(1'b1, 32'h8C250000, 32'h800);
    step();
    drive(1'b1, 32'h00A03021, 32'h804);
    #1;
    checks++;
    if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL ar_hz_setup: got %b expected 1", bus.if_stall); end
    #2;
    reset_n = 1'b0;
    #1;
    e = mk(RP, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({bus.id_valid, bus.if_stall} !== 2'b00) begin errors++; $display("FAIL ar_valid_stall: got %b expected 00", {bus.id_valid, bus.if_stall}); end
    checks++;
    if (obs() !== e) begin errors++; $display("FAIL ar_fields: got %h expected %h", obs(), e); end
    drive(1'b0, 32'h0, 32'h0);
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_bypass();
    test_load_use();
    test_stall_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/qm_decode.md
Name: qm_decode

Overview:
Instruction decode stage of the q3kmips 5-stage pipeline. It sits between fetch and execute and drives the read-address ports of the 3-port register file, taking that file's read data in return. It bypasses the same-cycle writeback value, detects load-use hazards and inserts bubbles. It registers decoded control and operands into the ID/EX pipeline register.

Parameters:
RESET_PC, 32'h0000_0000, value loaded into id_pc on reset.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
if_valid  in  1  fetch presents a valid instruction
if_instr  in  32  fetched instruction word
if_pc  in  32  PC of if_instr
if_stall  out  1  fetch must hold if_instr/if_pc this cycle (combinational)
ex_stall  in  1  execute cannot accept; ID/EX register holds
ex_flush  in  1  branch taken in EX; kill the instruction being captured
rf_ra1  out  5  register file read address 1 = if_instr[25:21] (rs), combinational
rf_ra2  out  5  register file read address 2 = if_instr[20:16] (rt), combinational
rf_rd1  in  32  register file read data 1 (already 0 for r0)
rf_rd2  in  32  register file read data 2
wb_we  in  1  writeback write enable (same signal as register file we3)
wb_wa  in  5  writeback destination
wb_wd  in  32  writeback data
id_valid  out  1  ID/EX entry valid
id_pc  out  32  PC of the entry
id_rs_val  out  32  operand A
id_rt_val  out  32  operand B / store data
id_imm  out  32  extended immediate
id_dest  out  5  destination register
id_alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 SRL, 8 PASSB
id_alu_imm  out  1  operand B is id_imm
id_reg_we  out  1  writes id_dest
id_mem_rd  out  1  load word
id_mem_wr  out  1  store word
id_br_eq  out  1  BEQ
id_br_ne  out  1  BNE
id_illegal  out  1  unsupported opcode/funct

Behaviour:
- Reset (async, reset_n=0): id_pc=RESET_PC. All other id_* outputs are 0. if_stall=0 because id_valid=0.
- Latency: 1 cycle from if_instr to the id_* outputs.
- Decode for R-type (op 0):
  - ADDU 21, SUBU 23, AND 24, OR 25, XOR 26, SLT 2A: dest=rd.
  - SLL 00, SRL 02: id_imm=shamt zero-extended, alu_imm=1, dest=rd.
- Decode for I-type:
  - ADDIU 09: sign-extend. SLTI 0A: sign-extend. ANDI 0C, ORI 0D: zero-extend.
  - LUI 0F: id_imm={imm,16'h0}, op PASSB.
  - LW 23, SW 2B: ADD with sign-extended imm.
  - BEQ 04, BNE 05: SUB, alu_imm=0, reg_we=0, id_imm=sext(imm)<<2.
  - I-type ALU ops and LW: dest=rt.
- Illegal: any other opcode or funct gives id_illegal=1 with reg_we, mem_rd, mem_wr and br_* all 0. id_valid is still 1; EX raises the exception.
- dest==0: force id_reg_we=0.
- Bypass: if wb_we && wb_wa!=0 && wb_wa==rs then id_rs_val<=wb_wd, else rf_rd1. rt uses the same rule with rf_rd2.
- Load-use hazard (hz), combinational: all of the following hold:
  - id_valid, id_mem_rd and if_valid;
  - id_dest matches rs (for any instruction that reads rs) or rt (for R-type, SW, BEQ or BNE).
- if_stall = ex_stall | (hz & ~ex_flush).
- Update priority at a clock edge, highest first:
  - ex_stall: every id_* output holds.
  - ex_flush: id_valid<=0 and other fields are don't-care. if_stall is not asserted for hz here; fetch redirects.
  - hz: bubble (id_valid<=0). The instruction is held in fetch and re-decoded next cycle. The bypass then covers the load's writeback if it lands that cycle.
  - ~if_valid: id_valid<=0.
  - Otherwise: capture the decoded instruction with id_valid<=1.
- ex_stall together with ex_flush: the stall wins for that edge. The flush is expected to be held by EX until the stall drops.
- Reset mid-stall or mid-hazard: everything clears immediately and no entry survives.

Test Plan:
- Reset then ADDIU r2,r0,5 (0x24020005) with if_valid=1 -> next cycle id_valid=1, dest=2, imm=5, alu_op=0, alu_imm=1, reg_we=1.
- wb_we=1, wb_wa=3, wb_wd=0xDEAD_BEEF, rf_rd1=0 while decoding ADDU r4,r3,r0 -> id_rs_val=0xDEADBEEF. Same with wb_wa=0 -> id_rs_val=rf_rd1.
- LW r5,0(r1) followed by ADDU r6,r5,r0 -> if_stall=1 one cycle, bubble (id_valid=0), then ADDU captured; no stall if the follower is ADDIU r6,r7,1.
- ex_stall=1 for 3 cycles with valid entry -> all id_* unchanged, if_stall=1; ex_flush=1 with no stall -> id_valid=0 next cycle.
- Instruction 0xFC000000 -> id_illegal=1, reg_we=0, mem_rd=0, mem_wr=0, id_valid=1; ORI r0,r1,0xFFFF -> imm=0x0000FFFF, reg_we=0.
- Assert reset_n=0 asynchronously mid-cycle during hazard -> id_valid=0, id_pc=RESET_PC, if_stall=0 without waiting for clk.
